// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the block-memory read-port arbiter.
// Used by mem_rd_arbiter and its return-tag pipeline.
package mem_arb_pkg;

  localparam int LEN_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    last;
  } ret_ent_t;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len,
    input logic [LEN_W-1:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// mem_rd_arbiter_if: read port of the shared dual-port block memory.
// master = arbiter side, slave = memory side.
interface mem_rd_arbiter_if #(
  parameter int G_ADDRWIDTH = 10,
  parameter int G_DATAWIDTH = 32
);

  logic                   mem_enb;
  logic [G_ADDRWIDTH-1:0] mem_addrb;
  logic [G_DATAWIDTH-1:0] mem_doutb;

  modport master (
    output mem_enb,
    output mem_addrb,
    input  mem_doutb
  );

  modport slave (
    input  mem_enb,
    input  mem_addrb,
    output mem_doutb
  );

endinterface

// File: rtl/mem_rd_retpipe.sv
// mem_rd_retpipe: G_RDLATENCY-deep shift of {valid, id, last} tags
// that tracks read beats until their data leaves the memory.
module mem_rd_retpipe
  import mem_arb_pkg::*;
#(
  parameter int G_RDLATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  ret_ent_t din,
  output ret_ent_t dout,
  output logic     any_valid
);

  ret_ent_t pipe [G_RDLATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < G_RDLATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < G_RDLATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[G_RDLATENCY-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < G_RDLATENCY; i++) begin
      any_valid = any_valid | pipe[i].valid;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: two-requester read arbiter + burst sequencer.
// Define MEM_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int G_ADDRWIDTH = 10,
  parameter int G_DATAWIDTH = 32,
  parameter int G_MAXBURST  = 32,
  parameter int G_RDLATENCY = 1
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [G_ADDRWIDTH-1:0] addr0,
  input  logic [G_ADDRWIDTH-1:0] addr1,
  input  logic [LEN_W-1:0]       len0,
  input  logic [LEN_W-1:0]       len1,
  input  logic                   stall0,
  input  logic                   stall1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic                   rlast0,
  output logic                   rlast1,
  output logic [G_DATAWIDTH-1:0] rdata,
  output logic                   busy,
  mem_rd_arbiter_if.master       mem
);

  localparam logic [LEN_W-1:0] MAX_LEN =
    LEN_W'(G_MAXBURST - 1);

  state_t                 state;
  req_id_t                own;
  req_id_t                win;
  logic [G_ADDRWIDTH-1:0] addr_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic                   stall_own;
  logic                   issue;
  logic                   beat_last;
  logic                   any_req;
  ret_ent_t               ret_in;
  ret_ent_t               ret_out;
  logic                   ret_busy;

  assign any_req = req0 | req1;

`ifdef MEM_RD_ARB_FIXED_PRIO_EN
  assign win = req0 ? 1'b0 : 1'b1;
`else
  req_id_t ptr;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 && req1:  win = ptr;
      !req0 && req1: win = 1'b1;
      default:       win = 1'b0;
    endcase
  end

  // Pointer favours whoever did not win last.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      ptr <= !win;
    end
  end
`endif

  assign stall_own = own ? stall1 : stall0;
  assign issue     = (state == BURST) && !stall_own;
  assign beat_last = (cnt_q == len_q);

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state  <= IDLE;
      own    <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state  <= BURST;
            own    <= win;
            addr_q <= win ? addr1 : addr0;
            len_q  <= clamp_len(win ? len1 : len0,
                                MAX_LEN);
            cnt_q  <= '0;
            gnt0   <= !win;
            gnt1   <= win;
          end
        end
        BURST: begin
          if (issue) begin
            addr_q <= addr_q + G_ADDRWIDTH'(1);
            cnt_q  <= cnt_q + LEN_W'(1);
            if (beat_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ret_in = '{valid: issue,
                    id:    own,
                    last:  beat_last};

  mem_rd_retpipe #(
    .G_RDLATENCY(G_RDLATENCY)
  ) u_retpipe (
    .clk      (s_aclk),
    .rst      (s_areset),
    .din      (ret_in),
    .dout     (ret_out),
    .any_valid(ret_busy)
  );

  assign rvalid0 = ret_out.valid && !ret_out.id;
  assign rvalid1 = ret_out.valid && ret_out.id;
  assign rlast0  = rvalid0 && ret_out.last;
  assign rlast1  = rvalid1 && ret_out.last;
  assign rdata   = mem.mem_doutb;
  assign busy    = (state != IDLE) || ret_busy;

  assign mem.mem_enb   = issue;
  assign mem.mem_addrb = addr_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed table, corner sequences and a
// queue-based random model for mem_rd_arbiter.
module tb_mem_rd_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int MB  = 32;
  localparam int LAT = 1;
  localparam int RND = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, req1, stall0, stall1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    len0, len1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic          rlast0, rlast1, busy;
  logic [DW-1:0] rdata;

  int checks   = 0;
  int failures = 0;

  mem_rd_arbiter_if #(
    .G_ADDRWIDTH(AW), .G_DATAWIDTH(DW)
  ) mif ();

  mem_rd_arbiter #(
    .G_ADDRWIDTH(AW), .G_DATAWIDTH(DW),
    .G_MAXBURST(MB), .G_RDLATENCY(LAT)
  ) dut (
    .s_aclk(clk), .s_areset(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1),
    .stall0(stall0), .stall1(stall1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rlast0(rlast0), .rlast1(rlast1),
    .rdata(rdata), .busy(busy),
    .mem(mif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return 32'h1234_0000 ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  // Memory model: registered read with LAT cycles of latency.
  logic [DW-1:0] dq [LAT];
  assign mif.mem_doutb = dq[LAT-1];
  always @(posedge clk) begin
    if (mif.mem_enb) dq[0] <= mem_val(mif.mem_addrb);
    for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          r1;
    logic [AW-1:0] a;
    logic [7:0]    l;
    int            beats;
    logic [AW-1:0] last_a;
  } vec_t;

  typedef struct {
    int            id;
    logic [AW-1:0] a;
    bit            last;
    int            cyc;
  } beat_t;

  task automatic run_vec(input vec_t v);
    int gat = -1, nb = 0, nrv = 0;
    bit got = 0;
    int enb_c[$];
    logic [AW-1:0] la = '0, ea;
    @(posedge clk); #1;
    if (v.r1) begin
      req1 = 1; addr1 = v.a; len1 = v.l;
    end else begin
      req0 = 1; addr0 = v.a; len0 = v.l;
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        chk("vec_gnt_id", {30'd0, gnt1, gnt0},
            v.r1 ? 32'd2 : 32'd1);
        if (!got) gat = c;
        got = 1; req0 = 0; req1 = 0;
      end
      if (mif.mem_enb) begin
        ea = v.a + AW'(nb);
        chk("vec_enb_addr", 32'(mif.mem_addrb), 32'(ea));
        la = mif.mem_addrb;
        enb_c.push_back(c);
        nb++;
      end
      if (rvalid0 || rvalid1) begin
        chk("vec_rv_id", {30'd0, rvalid1, rvalid0},
            v.r1 ? 32'd2 : 32'd1);
        if (enb_c.size() > 0)
          chk("vec_rv_lat", c - enb_c.pop_front(), LAT);
        else
          chk("vec_rv_spurious", 1, 0);
        ea = v.a + AW'(nrv);
        chk("vec_rdata", rdata, mem_val(ea));
        chk("vec_rlast", {31'd0, rlast0 | rlast1},
            (nrv == v.beats - 1) ? 32'd1 : 32'd0);
        nrv++;
      end
      if (got && !busy) break;
    end
    chk("vec_gnt_latency", gat, 1);
    chk("vec_beats", nb, v.beats);
    chk("vec_last_addr", 32'(la), 32'(v.last_a));
    chk("vec_rvalid_cnt", nrv, v.beats);
    chk("vec_idle_end", {31'd0, busy}, 0);
  endtask

  task automatic contend(input logic [AW-1:0] a0, a1,
                         input logic [7:0] l0, l1,
                         output int first, output int second,
                         output int gap, output int nb0,
                         output int nb1);
    int ord[$];
    int cur = 0, last_a = -1, first_b = -1;
    int nbt[2] = '{0, 0};
    @(posedge clk); #1;
    req0 = 1; req1 = 1;
    addr0 = a0; addr1 = a1; len0 = l0; len1 = l1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (gnt0) begin ord.push_back(0); req0 = 0; cur = 0; end
      if (gnt1) begin ord.push_back(1); req1 = 0; cur = 1; end
      if (mif.mem_enb) begin
        if (ord.size() == 1) last_a = c;
        else if (ord.size() == 2 && first_b < 0) first_b = c;
        nbt[cur]++;
      end
      if (ord.size() == 2 && !busy) break;
    end
    first  = (ord.size() > 0) ? ord[0] : -1;
    second = (ord.size() > 1) ? ord[1] : -1;
    gap = first_b - last_a;
    nb0 = nbt[0];
    nb1 = nbt[1];
  endtask

  function automatic logic [7:0] rnd_len();
    if ($urandom_range(0, 9) == 0)
      return 8'($urandom_range(32, 255));
    return 8'($urandom_range(0, 12));
  endfunction

  vec_t tbl [8];

  initial begin
    int f, s, g, n0, n1;
    int nb, stc, viol, rv_st, nrv, nrl;
    logic [AW-1:0] res_a;
    bit got;

    tbl[0] = '{1'b0, 10'h010, 8'd0,   1,  10'h010};
    tbl[1] = '{1'b1, 10'h3FE, 8'd200, 32, 10'h01D};
    tbl[2] = '{1'b0, 10'h100, 8'd3,   4,  10'h103};
    tbl[3] = '{1'b1, 10'h000, 8'd31,  32, 10'h01F};
    tbl[4] = '{1'b0, 10'h3F0, 8'd255, 32, 10'h00F};
    tbl[5] = '{1'b1, 10'h050, 8'd32,  32, 10'h06F};
    tbl[6] = '{1'b0, 10'h3FF, 8'd1,   2,  10'h000};
    tbl[7] = '{1'b1, 10'h123, 8'd30,  31, 10'h141};

    req0 = 0; req1 = 0; stall0 = 0; stall1 = 0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;

    repeat (2) @(negedge clk);
    chk("rst_outs", {24'd0, gnt0, gnt1, rvalid0, rvalid1,
        rlast0, rlast1, busy, mif.mem_enb}, 0);
    chk("rst_addr", 32'(mif.mem_addrb), 0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Tie twice: RR hands over, then requester 0 first again.
    contend(10'h200, 10'h300, 8'd3, 8'd3, f, s, g, n0, n1);
    chk("rr_first", f, 0);
    chk("rr_second", s, 1);
    chk("rr_gap", g, 2);
    chk("rr_beats0", n0, 4);
    chk("rr_beats1", n1, 4);
    contend(10'h210, 10'h310, 8'd0, 8'd2, f, s, g, n0, n1);
    chk("rr_next_tie", f, 0);
    chk("rr_next_beats1", n1, 3);

    // Stall after three beats for three cycles.
    @(posedge clk); #1;
    req1 = 1; addr1 = 10'h080; len1 = 8'd7;
    nb = 0; stc = 0; viol = 0; rv_st = 0; nrv = 0; nrl = 0;
    res_a = '0; got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (gnt1) begin req1 = 0; got = 1; end
      if (mif.mem_enb) begin
        if (stall1) viol++;
        if (nb == 3) res_a = mif.mem_addrb;
        nb++;
      end
      if (rvalid1) begin
        if (stall1) rv_st++;
        if (rlast1) nrl++;
        nrv++;
      end
      if (got && !busy) break;
      @(posedge clk); #1;
      stall1 = (nb == 3 && stc < 3);
      if (stall1) stc++;
    end
    stall1 = 0;
    chk("stall_cycles", stc, 3);
    chk("stall_no_enb", viol, 0);
    chk("stall_resume", 32'(res_a), 32'h083);
    chk("stall_beats", nb, 8);
    chk("stall_rvalid", nrv, 8);
    chk("stall_rlast", nrl, 1);
    chk("stall_inflight", {31'd0, rv_st > 0}, 1);

    // Random traffic against the queue model.
    begin
      beat_t iss_q[$];
      beat_t ret_q[$];
      beat_t it;
      logic s0, s1;
      int w, ew, nbst, lw = 1;
      logic [AW-1:0] base;
      logic [7:0] ln;
      for (int cyc = 0; cyc < RND + 2000; cyc++) begin
        @(posedge clk);
        s0 = req0; s1 = req1;
        #1;
        if (cyc < RND) begin
          if (!req0 && $urandom_range(0, 3) == 0) begin
            req0 = 1; addr0 = AW'($urandom); len0 = rnd_len();
          end
          if (!req1 && $urandom_range(0, 3) == 0) begin
            req1 = 1; addr1 = AW'($urandom); len1 = rnd_len();
          end
          stall0 = ($urandom_range(0, 4) == 0);
          stall1 = ($urandom_range(0, 4) == 0);
        end else begin
          stall0 = 0; stall1 = 0;
        end
        @(negedge clk);
        if (gnt0 && gnt1) chk("rnd_gnt_onehot", 1, 0);
        if (gnt0 || gnt1) begin
          w = gnt1 ? 1 : 0;
`ifdef MEM_RD_ARB_FIXED_PRIO_EN
          ew = (s0 && s1) ? 0 : (s1 ? 1 : 0);
`else
          ew = (s0 && s1) ? 1 - lw : (s1 ? 1 : 0);
`endif
          chk("rnd_arb", w, ew);
          base = w ? addr1 : addr0;
          ln = w ? len1 : len0;
          nbst = (int'(ln) < MB - 1) ? int'(ln) + 1 : MB;
          for (int k = 0; k < nbst; k++) begin
            it.id = w;
            it.a = base + AW'(k);
            it.last = (k == nbst - 1);
            it.cyc = 0;
            iss_q.push_back(it);
          end
          if (w == 1) req1 = 0; else req0 = 0;
          lw = w;
        end
        chk("rnd_busy", {31'd0, busy},
            (iss_q.size() > 0 || ret_q.size() > 0) ? 1 : 0);
        if (mif.mem_enb) begin
          if (iss_q.size() == 0) chk("rnd_enb_spurious", 1, 0);
          else begin
            it = iss_q.pop_front();
            chk("rnd_stall", {31'd0, it.id == 1 ? stall1 : stall0}, 0);
            chk("rnd_addr", 32'(mif.mem_addrb), 32'(it.a));
            it.cyc = cyc;
            ret_q.push_back(it);
          end
        end
        if (rvalid0 || rvalid1) begin
          if (ret_q.size() == 0) chk("rnd_rv_spurious", 1, 0);
          else begin
            it = ret_q.pop_front();
            chk("rnd_rv_id", {30'd0, rvalid1, rvalid0},
                it.id == 1 ? 32'd2 : 32'd1);
            chk("rnd_rv_lat", cyc - it.cyc, LAT);
            chk("rnd_rdata", rdata, mem_val(it.a));
            chk("rnd_rlast", {31'd0, rlast0 | rlast1},
                {31'd0, it.last});
          end
        end
        if (cyc >= RND && !req0 && !req1 && !busy &&
            iss_q.size() == 0 && ret_q.size() == 0) break;
      end
      chk("rnd_drained", {29'd0, req0, req1, busy}, 0);
      chk("rnd_queues_empty", iss_q.size() + ret_q.size(), 0);
    end

    // Reset in the middle of a 16-beat burst.
    @(posedge clk); #1;
    req0 = 1; addr0 = 10'h040; len0 = 8'd15;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 0;
      if (mif.mem_enb) nb++;
      if (nb == 5) break;
    end
    chk("mid_rst_beats_before", nb, 5);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("mid_rst_outs", {24'd0, gnt0, gnt1, rvalid0, rvalid1,
        rlast0, rlast1, busy, mif.mem_enb}, 0);
    nrv = 0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid0 || rvalid1 || rlast0 || rlast1) nrv++;
    end
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid0 || rvalid1 || rlast0 || rlast1) nrv++;
    end
    chk("mid_rst_no_rvalid", nrv, 0);
    chk("mid_rst_idle", {31'd0, busy}, 0);
    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Two-requester read-port arbiter and burst sequencer for the read port (enb/addrb/doutb) of the shared dual-port block memory.
- Requester 0 is the host single-word read path. Requester 1 is the AXI-stream frame reader.
- Each grant issues a contiguous burst of incrementing addresses, one per cycle.
- Read data is returned to the owning requester after the fixed memory latency, with valid and last flags tagged by requester.

Parameters:
- G_ADDRWIDTH, 10, memory word-address width.
- G_DATAWIDTH, 32, memory data width.
- G_MAXBURST, 32, maximum beats per grant; must be a power of 2, 2..256.
- G_RDLATENCY, 1, cycles from mem_enb to valid mem_doutb; range 1..4.

Ports:
- s_aclk  in  1  clock.
- s_areset  in  1  reset, asynchronous, active-high.
- req0, req1  in  1 each  burst request; held until gnt pulse.
- addr0, addr1  in  G_ADDRWIDTH each  burst start word address.
- len0, len1  in  8 each  burst beats minus 1.
- stall0, stall1  in  1 each  owner not ready; pauses address issue.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted.
- rvalid0, rvalid1  out  1 each  return-data valid for that requester.
- rlast0, rlast1  out  1 each  final beat of burst, coincident with rvalid.
- rdata  out  G_DATAWIDTH  shared return data (mem_doutb pass-through).
- busy  out  1  burst in progress or return pipeline non-empty.
- mem_enb  out  1  memory read enable.
- mem_addrb  out  G_ADDRWIDTH  memory read address.
- mem_doutb  in  G_DATAWIDTH  memory read data.

Behaviour:
- Reset (async assert, sync release): state IDLE, RR pointer favours requester 0, counters 0, return pipeline flushed. Reset value 0 on every output except rdata, which follows mem_doutb.
- States:
  - IDLE:
    - Sample req0/req1.
    - If any request is set, select the winner, latch its addr/len, register gnt, and go to BURST.
    - gntN pulses the cycle after the request is seen.
    - Only one gnt per cycle.
  - BURST:
    - When stall of the owner is 0: assert mem_enb with mem_addrb = current address. Then address+1, wrapping modulo 2^G_ADDRWIDTH (0x3FF -> 0x000). Then beat count+1.
    - When stall is 1: mem_enb = 0 and the address holds.
    - After the beat with count == latched len, go to IDLE.
  - The IDLE cycle separates bursts, so a back-to-back grant leaves a 1-cycle address gap.
- Arbitration (default):
  - Round-robin. The pointer moves to the other requester after each grant.
  - With both requesting, the pointed requester wins.
  - A lone requester always wins regardless of pointer.
- Length clamp: the effective length is min(lenN, G_MAXBURST-1), using 8-bit unsigned compare.
- Ownership: a request cleared mid-burst does not abort. The burst completes; the requester must absorb the data.
- Return pipeline:
  - G_RDLATENCY-deep shift of {valid, owner, last}, loaded on each mem_enb.
  - rvalidN/rlastN assert exactly G_RDLATENCY cycles after the matching mem_enb.
  - stall never stops in-flight data; the requester must absorb up to G_RDLATENCY beats after raising stall.
- busy = (state != IDLE) OR any pipeline valid.
- Reset mid-burst: issue stops immediately. In-flight beats are dropped with no rvalid and no rlast.
- Single-word read: len = 0 gives one mem_enb and one rvalid with rlast = 1.

Optional Feature:
- Macro: MEM_RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins a tie and the RR pointer logic is removed.
- Undefined: round-robin as above.
- Starvation of requester 1 under continuous req0 is accepted only when the macro is defined.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum IDLE/BURST.
  - requester-id typedef (1 bit).
  - return-pipeline entry struct {valid, id, last}.
  - constant for the length width (8).
- One sub-module: mem_rd_retpipe, the parameterised G_RDLATENCY shift register for return tags.

Test Plan:
- Single read: req0, addr0=0x010, len0=0 -> gnt0 one cycle later, one mem_enb at 0x010, rvalid0 + rlast0 G_RDLATENCY cycles later, rdata = memory[0x010].
- Contention, RR: req0 and req1 together, len=3 each -> requester 0 gets 4 beats; IDLE gap; requester 1 gets 4 beats; next tie goes to requester 0.
- Wrap and clamp: req1, addr1=0x3FE, len1=200, G_MAXBURST=32 -> 32 beats with addresses 0x3FE, 0x3FF, 0x000..0x01D; rlast1 on the 32nd beat.
- Stall: req1 len1=7, stall1 high for 3 cycles after beat 2 -> no mem_enb during the stall, address resumes at start+3, total 8 rvalid1, in-flight beat delivered during the stall.
- Reset mid-burst: assert s_areset at beat 5 of 16 -> all outputs 0 asynchronously, no further rvalid; after release, busy=0 and a new req0 is granted normally.
- With MEM_RD_ARB_FIXED_PRIO_EN: continuous req0 (len=0) with req1 pending -> gnt1 never asserts while req0 is held; gnt1 follows the first IDLE in which req0 is low.
